// File: rtl/ldx_pipe_pkg.sv
// ldx_pipe_pkg: load funct3 encodings and load-context header shared by the load-return path.
package ldx_pipe_pkg;
    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] addr_end;
    } ld_hdr_t;
endpackage

// File: rtl/ldx_pipe_extract.sv
// ld_extract: byte/halfword select from an aligned read word plus sign/zero extension.
module ld_extract
    import ldx_pipe_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_end,
    output logic [31:0] result,
    output logic        illegal
);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;

    assign sh = data >> {addr_end, 3'b000};
    assign b  = sh[7:0];
    // Halfword select ignores addr_end[0], mirroring the store aligner.
    assign h  = addr_end[1] ? data[31:16] : data[15:0];

    always_comb begin
        result = funct3 == FNC_LB  ? {{24{b[7]}}, b}  :
                 funct3 == FNC_LBU ? {24'b0, b}       :
                 funct3 == FNC_LH  ? {{16{h[15]}}, h} :
                 funct3 == FNC_LHU ? {16'b0, h}       : data;
        illegal = !(funct3 inside {FNC_LB, FNC_LH, FNC_LW, FNC_LBU, FNC_LHU});
    end
endmodule

// File: rtl/ldx_pipe.sv
// ldx_pipe: queues issued-load context and turns returning read words into extended writeback results.
module ldx_pipe
    import ldx_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int RD_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_funct3,
    input  logic [1:0]               req_addr_end,
    input  logic [RD_W-1:0]          req_rd,
    input  logic                     mem_resp_valid,
    output logic                     mem_resp_ready,
    input  logic [31:0]              mem_resp_data,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [31:0]              wb_data,
    output logic [RD_W-1:0]          wb_rd,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(2 * DEPTH);

    typedef struct packed {
        ld_hdr_t         hdr;
        logic [RD_W-1:0] rd;
    } ctx_t;

    ctx_t          mem [DEPTH];
    ctx_t          head;
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [DW-1:0] drop_cnt, drop_sat;
    logic [DW:0]   dsum;
    logic          push, acc, drop, pop, stray, illegal;
    logic [31:0]   ext_data;

    assign head           = mem[rptr];
    assign pending        = count;
    assign req_ready      = count < CW'(DEPTH);
    assign mem_resp_ready = !wb_valid || wb_ready;
    assign push           = req_valid && req_ready && !flush;
    assign acc            = mem_resp_valid && mem_resp_ready;
    assign drop           = acc && drop_cnt != '0;
    assign pop            = acc && drop_cnt == '0 && count != '0;
    assign stray          = acc && drop_cnt == '0 && count == '0;
    // On flush every queued load becomes a response to discard, less the one consumed this cycle.
    assign dsum     = {1'b0, drop_cnt} + (DW+1)'(count) - (DW+1)'(acc && (drop_cnt != '0 || count != '0));
    assign drop_sat = dsum > (DW+1)'(2 * DEPTH - 1) ? DW'(2 * DEPTH - 1) : dsum[DW-1:0];

    ld_extract u_extract (
        .data     (mem_resp_data),
        .funct3   (head.hdr.funct3),
        .addr_end (head.hdr.addr_end),
        .result   (ext_data),
        .illegal  (illegal)
    );

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= '{hdr: '{funct3: req_funct3, addr_end: req_addr_end}, rd: req_rd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            drop_cnt <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= '0;
            err      <= 1'b0;
        end else begin
            err <= err | stray | (pop & illegal);
            if (flush) begin
                wptr     <= '0;
                rptr     <= '0;
                count    <= '0;
                wb_valid <= 1'b0;
                drop_cnt <= drop_sat;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop) rptr <= rptr + 1'b1;
                count    <= count + CW'(push) - CW'(pop);
                drop_cnt <= drop_cnt - DW'(drop);
                if (pop) begin
                    wb_valid <= 1'b1;
                    wb_data  <= ext_data;
                    wb_rd    <= head.rd;
                end else if (wb_ready) begin
                    wb_valid <= 1'b0;
                end
            end
        end
    end
endmodule
